// File: rtl/mat_mult_seq.sv
// Sequential N x N matrix multiply: one shared MAC per cycle, C = A x B or C += A x B.
// C storage is one register per element, instantiated across a row/column generate grid.

module mm_elem #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic         accum,
  input  logic [W-1:0] sum,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (clr)  q <= '0;
    else if (we)   q <= (accum ? q : '0) + sum;
  end
endmodule

module mat_mult_seq #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW+$clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   signed_i,
  input  logic                   accum_i,
  input  logic                   clear_i,
  input  logic [N*N*DW-1:0]      mat_a_i,
  input  logic [N*N*DW-1:0]      mat_b_i,
  output logic [N*N*ACC_W-1:0]   mat_c_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int            IW   = $clog2(N);
  localparam int            EW   = $clog2(N*N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nx;

  logic [N*N-1:0][DW-1:0]    a, b;
  logic [N*N-1:0][ACC_W-1:0] cq;
  logic [N*N-1:0]            we;
  logic                      sgn, accm;
  logic [ACC_W-1:0]          acc, prod, sum;
  logic [IW-1:0]             i, j, k;
  logic [EW-1:0]             a_idx, b_idx;
  logic [DW-1:0]             a_el, b_el;
  logic [ACC_W-1:0]          a_ext, b_ext;
  logic                      take, clr, wr, last_k, last_el;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign last_k  = (k == LAST);
  assign last_el = (i == LAST) && (j == LAST);

  // start beats clear when both arrive together in IDLE
  always_comb begin
    state_nx = state;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    take     = 1'b0;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          take     = 1'b1;
          state_nx = MAC;
        end else if (clear_i) begin
          clr = 1'b1;
        end
      end
      MAC: begin
        busy_o = 1'b1;
        if (last_k && last_el) state_nx = DONE;
      end
      DONE: begin
        busy_o   = 1'b1;
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign a_idx = EW'(i) * EW'(N) + EW'(k);
  assign b_idx = EW'(k) * EW'(N) + EW'(j);
  assign a_el  = a[a_idx];
  assign b_el  = b[b_idx];

  // sign or zero extend to full width; the truncated product is then correct mod 2^ACC_W
  assign a_ext = {{(ACC_W-DW){sgn & a_el[DW-1]}}, a_el};
  assign b_ext = {{(ACC_W-DW){sgn & b_el[DW-1]}}, b_el};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + prod;
  assign wr    = (state == MAC) && last_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      b    <= '0;
      sgn  <= 1'b0;
      accm <= 1'b0;
      acc  <= '0;
      i    <= '0;
      j    <= '0;
      k    <= '0;
    end else if (take) begin
      a    <= mat_a_i;
      b    <= mat_b_i;
      sgn  <= signed_i;
      accm <= accum_i;
      acc  <= '0;
      i    <= '0;
      j    <= '0;
      k    <= '0;
    end else if (state == MAC) begin
      if (!last_k) begin
        acc <= sum;
        k   <= k + 1'b1;
      end else begin
        acc <= '0;
        k   <= '0;
        if (j == LAST) begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar cc = 0; cc < N; cc++) begin : g_col
      assign we[r*N+cc] = wr && (i == IW'(r)) && (j == IW'(cc));
      mm_elem #(.W(ACC_W)) u_elem (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (we[r*N+cc]),
        .accum (accm),
        .sum   (sum),
        .q     (cq[r*N+cc])
      );
    end
  end

  assign mat_c_o = cq;
endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: an N=2 and an N=4 instance checked against a
// plain-arithmetic matrix model that tracks the expected C contents of each instance.

module tb_mat_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         st2 = 0, cl2 = 0, sg2 = 0, ac2 = 0, bz2, dn2;
  logic [31:0]  a2 = '0, b2 = '0;
  logic [67:0]  c2;
  logic         st4 = 0, cl4 = 0, sg4 = 0, ac4 = 0, bz4, dn4;
  logic [127:0] a4 = '0, b4 = '0;
  logic [287:0] c4;

  mat_mult_seq #(.N(2), .DW(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(st2), .signed_i(sg2), .accum_i(ac2),
    .clear_i(cl2), .mat_a_i(a2), .mat_b_i(b2), .mat_c_o(c2), .busy_o(bz2), .done_o(dn2)
  );

  mat_mult_seq u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(st4), .signed_i(sg4), .accum_i(ac4),
    .clear_i(cl4), .mat_a_i(a4), .mat_b_i(b4), .mat_c_o(c4), .busy_o(bz4), .done_o(dn4)
  );

  int     tests = 0, fails = 0;
  int     ea[16], eb[16];
  longint ref2[4], ref4[16];

  task automatic chk(string tag, longint got, longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ext(int v, bit s);
    return (s && v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  function automatic longint dot(int n, int r, int c, bit s);
    longint acc = 0;
    for (int kk = 0; kk < n; kk++) acc += ext(ea[r*n+kk], s) * ext(eb[kk*n+c], s);
    return acc;
  endfunction

  task automatic model(int n, bit s, bit accm);
    longint mask = (longint'(1) << ((n == 2) ? 17 : 18)) - 1;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        if (n == 2) ref2[r*2+c] = ((accm ? ref2[r*2+c] : 0) + dot(n, r, c, s)) & mask;
        else        ref4[r*4+c] = ((accm ? ref4[r*4+c] : 0) + dot(n, r, c, s)) & mask;
      end
  endtask

  function automatic longint cel(int n, int idx);
    return (n == 2) ? longint'(c2[idx*17 +: 17]) : longint'(c4[idx*18 +: 18]);
  endfunction

  function automatic bit busy(int n);
    return (n == 2) ? bz2 : bz4;
  endfunction

  function automatic bit done(int n);
    return (n == 2) ? dn2 : dn4;
  endfunction

  task automatic check_c(int n, string tag);
    for (int idx = 0; idx < n*n; idx++)
      chk($sformatf("%s_c%0d", tag, idx), cel(n, idx), (n == 2) ? ref2[idx] : ref4[idx]);
  endtask

  task automatic drive_ops(int n);
    for (int idx = 0; idx < n*n; idx++) begin
      if (n == 2) begin a2[idx*8 +: 8] = 8'(ea[idx]); b2[idx*8 +: 8] = 8'(eb[idx]); end
      else        begin a4[idx*8 +: 8] = 8'(ea[idx]); b4[idx*8 +: 8] = 8'(eb[idx]); end
    end
  endtask

  task automatic set_ctl(int n, bit st, bit cl, bit sg, bit ac);
    if (n == 2) begin st2 = st; cl2 = cl; sg2 = sg; ac2 = ac; end
    else        begin st4 = st; cl4 = cl; sg4 = sg; ac4 = ac; end
  endtask

  task automatic scramble(int n);
    if (n == 2) begin a2 = $urandom; b2 = $urandom; end
    else begin
      for (int w = 0; w < 4; w++) begin a4[w*32 +: 32] = $urandom; b4[w*32 +: 32] = $urandom; end
    end
  endtask

  // One full run; accumulate runs also raise clear alongside start, which must lose.
  task automatic run(int n, bit sg, bit ac, bit disturb, string tag);
    int cnt = 0, bcnt = 0;
    bit got = 0;
    @(negedge clk);
    drive_ops(n);
    set_ctl(n, 1'b1, ac, sg, ac);
    @(posedge clk); #1;
    set_ctl(n, 1'b0, 1'b0, !sg, !ac);
    scramble(n);
    if (busy(n)) bcnt++;
    chk({tag, "_busy0"}, busy(n), 1);
    while (cnt < 1000 && !got) begin
      if (disturb && cnt == 3) begin set_ctl(n, 1'b1, 1'b1, !sg, !ac); scramble(n); end
      else if (disturb && cnt == 4) set_ctl(n, 1'b0, 1'b0, !sg, !ac);
      @(posedge clk); #1;
      cnt++;
      if (busy(n)) bcnt++;
      if (done(n)) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_done_lat"}, cnt, n*n*n);
    chk({tag, "_busy_cyc"}, bcnt, n*n*n + 1);
    model(n, sg, ac);
    check_c(n, tag);
    @(posedge clk); #1;
    chk({tag, "_done_off"}, done(n), 0);
    chk({tag, "_busy_off"}, busy(n), 0);
  endtask

  initial begin
    int dseen;
    for (int x = 0; x < 4; x++) ref2[x] = 0;
    for (int x = 0; x < 16; x++) ref4[x] = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy2", bz2, 0);
    chk("rst_done2", dn2, 0);
    chk("rst_busy4", bz4, 0);
    check_c(2, "rst");
    check_c(4, "rst4");
    @(negedge clk) rst_n = 1'b1;

    // basic unsigned
    ea[0:3] = '{1, 2, 3, 4};
    eb[0:3] = '{5, 6, 7, 8};
    run(2, 0, 0, 0, "basic");
    chk("basic_c00_abs", cel(2, 0), 19);
    chk("basic_c11_abs", cel(2, 3), 50);

    // accumulate, then clear in IDLE
    run(2, 0, 1, 0, "accum");
    chk("accum_c11_abs", cel(2, 3), 100);
    @(negedge clk) cl2 = 1'b1;
    @(posedge clk); #1;
    cl2 = 1'b0;
    for (int x = 0; x < 4; x++) ref2[x] = 0;
    check_c(2, "clear");

    // start/clear pulses and operand changes mid-run
    run(2, 0, 0, 1, "robust");
    chk("robust_c10_abs", cel(2, 2), 43);

    // signed vs unsigned interpretation
    ea[0:3] = '{255, 0, 0, 255};
    eb[0:3] = '{2, 3, 4, 5};
    run(2, 1, 0, 0, "signed");
    chk("signed_c00_abs", cel(2, 0), 131070);
    run(2, 0, 0, 0, "unsigned");
    chk("unsigned_c11_abs", cel(2, 3), 1275);

    // reset mid-run
    ea[0:3] = '{1, 2, 3, 4};
    eb[0:3] = '{5, 6, 7, 8};
    @(negedge clk);
    drive_ops(2);
    set_ctl(2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_ctl(2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int x = 0; x < 4; x++) ref2[x] = 0;
    for (int x = 0; x < 16; x++) ref4[x] = 0;
    chk("midrst_busy", bz2, 0);
    chk("midrst_done", dn2, 0);
    check_c(2, "midrst");
    dseen = 0;
    repeat (4) begin @(posedge clk); #1; if (dn2) dseen++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (dn2) dseen++; end
    chk("midrst_nodone", dseen, 0);
    run(2, 0, 0, 0, "postrst");

    // N=4: identity times 0..15, then all 0xFF
    for (int x = 0; x < 16; x++) begin
      ea[x] = (x / 4 == x % 4) ? 1 : 0;
      eb[x] = x;
    end
    run(4, 0, 0, 0, "ident");
    chk("ident_c9_abs", cel(4, 9), 9);
    for (int x = 0; x < 16; x++) begin ea[x] = 255; eb[x] = 255; end
    run(4, 0, 0, 0, "allff");
    chk("allff_c15_abs", cel(4, 15), 260100);

    // randomized runs against the model
    for (int t = 0; t < 8; t++) begin
      int n = (t % 2 == 0) ? 2 : 4;
      for (int x = 0; x < 16; x++) begin
        ea[x] = int'($urandom_range(0, 255));
        eb[x] = int'($urandom_range(0, 255));
      end
      run(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(t % 3 == 0),
          $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mat_mult_seq.md
# mat_mult_seq

Parametrised sequential matrix-multiply engine, the successor to the fixed 2x2 `multiply_long` accelerator. On a start pulse it captures two N x N operand matrices, computes C = A x B (or C += A x B in accumulate mode) with a single shared multiply-accumulate unit, one MAC per cycle, and signals completion with a one-cycle done pulse. It sits in the accelerator subsystem behind the core's register interface, which drives operands and reads results.

## Interface

- `N`, default 4: matrix dimension, N >= 2.
- `DW`, default 8: operand element width in bits.
- `ACC_W`, default 2*DW+$clog2(N): result element width in bits.

Ports:

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start_i` in 1: start request; sampled only in IDLE.
- `signed_i` in 1: 1 = two's-complement operands, 0 = unsigned; captured at start.
- `accum_i` in 1: 1 = C += A x B, 0 = C = A x B; captured at start.
- `clear_i` in 1: synchronous clear of C; honoured only in IDLE.
- `mat_a_i` in N*N*DW: A, row-major; element (r,c) at [(r*N+c)*DW +: DW].
- `mat_b_i` in N*N*DW: B, same layout.
- `mat_c_o` out N*N*ACC_W: C, registered, row-major; element (r,c) at [(r*N+c)*ACC_W +: ACC_W].
- `busy_o` out 1: high in MAC and DONE states.
- `done_o` out 1: one-cycle pulse when C is final.

## Operation

- States: IDLE, MAC, DONE.
- IDLE: if `start_i`, capture `mat_a_i`, `mat_b_i`, `signed_i` and `accum_i` into internal registers, zero the partial-sum register, set i=j=k=0, and go to MAC. If `clear_i` and not `start_i`, set all C to 0. If `start_i` and `clear_i` are both high, start wins and clear is ignored.
- MAC, each cycle:
  - p = A[i][k]*B[k][j], with both factors sign- or zero-extended per the captured mode.
  - If k<N-1: acc += p; k++.
  - If k==N-1: C[i][j] <= (accum ? C[i][j] : 0) + acc + p; acc <= 0; k <= 0; advance j, and on j wrap advance i.
  - After writing element (N-1,N-1), go to DONE.
- DONE: `done_o`=1 for this one cycle, then go to IDLE.
- Operands on `mat_a_i`/`mat_b_i` may change freely after the start edge; only the captured copies are used.
- Arithmetic: products and sums use ACC_W bits and wrap modulo 2^ACC_W. In signed mode the results are two's complement. No saturation and no overflow flag.
- `start_i` or `clear_i` while busy: ignored, with no queueing.
- C elements not yet written in the current run keep their previous values until overwritten.

## Timing

- Reset (async assert, sync deassert expected from the system): state=IDLE, all C=0, acc=0, i=j=k=0, `busy_o`=0, `done_o`=0.
- Start accepted at edge 0. MAC updates occur on edges 1..N^3. Element (i,j) becomes visible after edge (i*N+j+1)*N.
- Edge N^3 enters DONE. `done_o`=1 and `busy_o`=1 in the cycle after edge N^3, and the final C is valid in that same cycle.
- Edge N^3+1 returns to IDLE. `busy_o`=0 and `done_o`=0.
- A new start may be accepted at edge N^3+2 at the earliest.
- Reset mid-operation aborts immediately. C is zeroed and no `done_o` is produced.

## Test plan

- N=2, unsigned, accum=0, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]]; `done_o` high exactly one cycle, 9 cycles after the start edge; `busy_o` high 9 cycles.
- N=2, signed, A=[[0xFF,0],[0,0xFF]], B=[[2,3],[4,5]] -> C=[[-2,-3],[-4,-5]] in 17-bit two's complement; the same operands unsigned -> C=[[510,765],[1020,1275]].
- Accumulate: run the first test, then rerun with accum=1 -> C=[[38,44],[86,100]]. Then assert `clear_i` in IDLE -> all C=0 the next cycle.
- Robustness: pulse `start_i` and `clear_i` at cycle 3 of a run -> both ignored, result identical to the first test. Change `mat_a_i` after the start edge -> result unaffected.
- Reset mid-run: assert `rst_n`=0 at cycle 5 -> C=0, `busy_o`=0 immediately, no `done_o`. A subsequent start gives the correct result.
- N=4 default: A=identity, B with elements 0..15 -> C=B; `done_o` high 65 cycles after the start edge. Also run an all-0xFF unsigned case -> every C element = 4*65025 = 260100, which fits in 18 bits.
